// File: rtl/uart_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_wb_bridge
// Purpose  : UART command-frame receiver that runs single 32-bit Wishbone
//            master cycles and replies with a status byte (+ read data).
//            Optional feature macro: UART_WB_BRIDGE_TIMEOUT_EN
// Revision : 1.0  initial release
// ============================================================================
module uart_wb_bridge #(
    parameter int CLK_FREQ    = 40000000,
    parameter int BAUD_RATE   = 9600,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rx,
    output logic        tx,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        err_o
);

    localparam int c_clk_div = CLK_FREQ / BAUD_RATE;
    localparam int c_cnt_w   = $clog2(c_clk_div);
    localparam logic [c_cnt_w-1:0] c_bit_end = c_cnt_w'(c_clk_div - 1);
    localparam logic [c_cnt_w-1:0] c_half    = c_cnt_w'(c_clk_div / 2 - 1);
    localparam logic [7:0] c_cmd_wr = 8'h57;
    localparam logic [7:0] c_cmd_rd = 8'h52;
    localparam logic [7:0] c_ack    = 8'h06;
    localparam logic [7:0] c_nak    = 8'h15;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ADDR        = 3'd1,
        ST_DATA        = 3'd2,
        ST_BUS         = 3'd3,
        ST_RESP_STATUS = 3'd4,
        ST_RESP_DATA   = 3'd5
    } state_t;

    // receive engine
    logic               rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t          rx_state_q, rx_state_d;
    logic [c_cnt_w-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_ferr_q, rx_ferr_d;

    // transmit engine
    logic [9:0]         tx_shift_q, tx_shift_d;
    logic [c_cnt_w-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]         tx_bit_q, tx_bit_d;
    logic               tx_busy_q, tx_busy_d;
    logic               tx_done_q, tx_done_d;
    logic               tx_start;
    logic [7:0]         tx_data;

    // command FSM
    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         status_q, status_d;
    logic               cyc_q, cyc_d;
    logic               sent_q, sent_d;
    logic               err_q, err_d;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    localparam int c_to_raw = $clog2(ACK_TIMEOUT + 1);
    localparam int c_to_w   = (c_to_raw < 8) ? 8 : ((c_to_raw > 32) ? 32 : c_to_raw);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(ACK_TIMEOUT - 1);
    localparam int c_gap_w  = $clog2(16 * c_clk_div + 1);
    localparam logic [c_gap_w-1:0] c_gap_limit = c_gap_w'(16 * c_clk_div);
    logic [c_to_w-1:0]  to_cnt_q, to_cnt_d;
    logic [c_gap_w-1:0] gap_cnt_q, gap_cnt_d;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // a glitch shorter than half a bit is ignored
                if (rx_cnt_q == c_half) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == c_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == c_bit_end) begin
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        if (!tx_busy_q) begin
            if (tx_start) begin
                tx_shift_d = {1'b1, tx_data, 1'b0};
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_busy_d  = 1'b1;
            end
        end else if (tx_cnt_q == c_bit_end) begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd9) begin
                tx_busy_d = 1'b0;
                tx_done_d = 1'b1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        cyc_d      = cyc_q;
        sent_d     = sent_q;
        err_d      = 1'b0;
        tx_start   = 1'b0;
        tx_data    = status_q;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        to_cnt_d  = (state_q == ST_BUS) ? to_cnt_q + 1'b1 : '0;
        gap_cnt_d = ((state_q == ST_ADDR || state_q == ST_DATA) && rx_state_q == RX_IDLE)
                    ? gap_cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_q) begin
                    byte_cnt_d = '0;
                    if (rx_shift_q == c_cmd_wr || rx_shift_q == c_cmd_rd) begin
                        we_d    = (rx_shift_q == c_cmd_wr);
                        state_d = ST_ADDR;
                    end else begin
                        status_d = c_nak;
                        err_d    = 1'b1;
                        sent_d   = 1'b0;
                        state_d  = ST_RESP_STATUS;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid_q) begin
                    adr_d      = {adr_q[23:0], rx_shift_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = we_q ? ST_DATA : ST_BUS;
                        cyc_d   = !we_q;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_q) begin
                    dat_d      = {dat_q[23:0], rx_shift_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    if (!we_q) rdata_d = wbm_dat_i;
                    cyc_d    = 1'b0;
                    status_d = c_ack;
                    sent_d   = 1'b0;
                    state_d  = ST_RESP_STATUS;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == c_to_last) begin
                    cyc_d    = 1'b0;
                    status_d = c_nak;
                    err_d    = 1'b1;
                    sent_d   = 1'b0;
                    state_d  = ST_RESP_STATUS;
                    to_cnt_d = '0;
`endif
                end
            end
            ST_RESP_STATUS: begin
                tx_start = !sent_q;
                if (!sent_q) sent_d = 1'b1;
                if (tx_done_q) begin
                    sent_d     = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = (status_q == c_ack && !we_q) ? ST_RESP_DATA : ST_IDLE;
                end
            end
            ST_RESP_DATA: begin
                tx_data  = rdata_q[31:24];
                tx_start = !sent_q;
                if (!sent_q) sent_d = 1'b1;
                if (tx_done_q) begin
                    rdata_d    = {rdata_q[23:0], 8'h00};
                    sent_d     = 1'b0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // a bad stop bit only aborts frame reception; a bus cycle or reply keeps going
        if (rx_ferr_q) begin
            err_d = 1'b1;
            if (state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_DATA) state_d = ST_IDLE;
        end
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        if ((state_q == ST_ADDR || state_q == ST_DATA) && gap_cnt_q == c_gap_limit) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdata_q    <= '0;
            status_q   <= '0;
            cyc_q      <= 1'b0;
            sent_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            cyc_q      <= cyc_d;
            sent_q     <= sent_d;
            err_q      <= err_d;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign tx        = tx_shift_q[0];
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q & we_q;
    assign wbm_sel_o = {4{cyc_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_wb_bridge
// Purpose  : Self-checking bench: serial frames in, Wishbone slave model,
//            serial reply decoder and a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_wb_bridge;

    localparam int c_div = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        rx;
    logic        tx;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy, err_o;

    uart_wb_bridge #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (1),
        .ACK_TIMEOUT(10)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .rx       (rx),
        .tx       (tx),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .busy     (busy),
        .err_o    (err_o)
    );

    initial forever #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          len;
        bit          acked;
        bit          stable;
    } txn_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          lat;
        int          gap;
        logic [7:0]  exp_status;
        int          exp_ndata;
        bit          exp_bus;
        bit          exp_we;
        int          exp_len;
        int          exp_err;
    } vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    int         cyc_num = 0;
    int         err_total = 0;
    int         ack_lat = 0;
    logic [31:0] rd_val = '0;
    logic [7:0] rxq[$];
    int         rx_t[$];
    txn_t       txnq[$];

    always @(posedge wb_clk_i) cyc_num <= cyc_num + 1;

    initial forever begin
        @(negedge wb_clk_i);
        if (err_o === 1'b1) err_total = err_total + 1;
    end

    // decodes whatever the bridge sends on tx
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge tx);
            t0 = cyc_num;
            repeat (c_div / 2) @(negedge wb_clk_i);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (c_div) @(negedge wb_clk_i);
                    b[i] = tx;
                end
                repeat (c_div) @(negedge wb_clk_i);
                rxq.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    // Wishbone slave: acks after ack_lat cycles of cyc (0 = never)
    initial begin
        txn_t cur;
        int   cnt;
        cnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            if (wbm_cyc_o === 1'b1) begin
                if (cnt == 0) begin
                    cur.we = wbm_we_o; cur.adr = wbm_adr_o; cur.dat = wbm_dat_o;
                    cur.sel = wbm_sel_o; cur.acked = 1'b0; cur.stable = (wbm_stb_o === 1'b1);
                end else if (wbm_stb_o !== 1'b1 || wbm_we_o !== cur.we || wbm_adr_o !== cur.adr ||
                             wbm_dat_o !== cur.dat || wbm_sel_o !== cur.sel) begin
                    cur.stable = 1'b0;
                end
                cnt++;
                if (ack_lat != 0 && cnt == ack_lat) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = rd_val;
                    cur.acked = 1'b1;
                end
            end else if (cnt != 0) begin
                cur.len = cnt;
                txnq.push_back(cur);
                cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        rx = 1'b0;
        repeat (c_div) @(negedge wb_clk_i);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_div) @(negedge wb_clk_i);
        end
        rx = stop;
        repeat (c_div) @(negedge wb_clk_i);
        rx = 1'b1;
        if (!stop) repeat (2 * c_div) @(negedge wb_clk_i);
        repeat (gap) @(negedge wb_clk_i);
    endtask

    function automatic logic [8:0] rx_at(input int i);
        if (i < rxq.size()) return {1'b0, rxq[i]};
        return 9'h100;
    endfunction

    function automatic txn_t txn_at(input int i);
        txn_t d;
        if (i < txnq.size()) return txnq[i];
        d.we = 1'bx; d.adr = 'x; d.dat = 'x; d.sel = 'x; d.len = -1; d.acked = 0; d.stable = 0;
        return d;
    endfunction

    function automatic vec_t mk(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] wdat,
                                input logic [31:0] rdat, input int lat, input int gap,
                                input logic [7:0] st, input int nd, input bit bus, input bit we,
                                input int len, input int err);
        vec_t v;
        v.cmd = cmd; v.adr = adr; v.wdat = wdat; v.rdat = rdat; v.lat = lat; v.gap = gap;
        v.exp_status = st; v.exp_ndata = nd; v.exp_bus = bus; v.exp_we = we;
        v.exp_len = len; v.exp_err = err;
        return v;
    endfunction

    // frame-level reference: what a host should see for a given command frame
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit valid;
        r = v;
        valid = (v.cmd == 8'h57) || (v.cmd == 8'h52);
        r.exp_bus    = valid;
        r.exp_we     = (v.cmd == 8'h57);
        r.exp_status = valid ? 8'h06 : 8'h15;
        r.exp_ndata  = (v.cmd == 8'h52) ? 4 : 0;
        r.exp_len    = valid ? v.lat : 0;
        r.exp_err    = valid ? 0 : 1;
        return r;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        int   rb, tb0, eb, k, nexp, maxgap;
        txn_t t;
        logic [31:0] rd;
        rb = rxq.size(); tb0 = txnq.size(); eb = err_total;
        ack_lat = v.lat;
        rd_val = v.rdat;
        send_byte(v.cmd, 1'b1, v.gap);
        if (v.cmd == 8'h57 || v.cmd == 8'h52)
            for (int i = 3; i >= 0; i--) send_byte(v.adr[8*i +: 8], 1'b1, v.gap);
        if (v.cmd == 8'h57)
            for (int i = 3; i >= 0; i--) send_byte(v.wdat[8*i +: 8], 1'b1, v.gap);
        nexp = 1 + v.exp_ndata;
        k = 0;
        while ((rxq.size() - rb < nexp || busy !== 1'b0) && k < 5000) begin
            @(negedge wb_clk_i);
            k++;
        end
        check({tag, ":resp_wait"}, 32'(k < 5000), 32'd1);
        repeat (200) @(negedge wb_clk_i);
        check({tag, ":resp_count"}, 32'(rxq.size() - rb), 32'(nexp));
        check({tag, ":status"}, 32'(rx_at(rb)), 32'(v.exp_status));
        rd = v.rdat;
        for (int i = 0; i < v.exp_ndata; i++)
            check({tag, ":rdata_byte"}, 32'(rx_at(rb + 1 + i)), 32'(rd[31 - 8*i -: 8]));
        check({tag, ":bus_cycles"}, 32'(txnq.size() - tb0), 32'(v.exp_bus));
        if (v.exp_bus) begin
            t = txn_at(tb0);
            check({tag, ":we"}, 32'(t.we), 32'(v.exp_we));
            check({tag, ":adr"}, t.adr, v.adr);
            check({tag, ":sel"}, 32'(t.sel), 32'hF);
            check({tag, ":cyc_len"}, 32'(t.len), 32'(v.exp_len));
            check({tag, ":stable"}, 32'(t.stable), 32'd1);
            if (v.exp_we) check({tag, ":wdat"}, t.dat, v.wdat);
        end
        check({tag, ":err_pulses"}, 32'(err_total - eb), 32'(v.exp_err));
        check({tag, ":busy_end"}, 32'(busy), 32'd0);
        if (v.exp_ndata == 4) begin
            maxgap = 0;
            if (rxq.size() - rb < 5) maxgap = 9999;
            else for (int i = 0; i < 4; i++)
                if (rx_t[rb+i+1] - rx_t[rb+i] > maxgap) maxgap = rx_t[rb+i+1] - rx_t[rb+i];
            check({tag, ":back_to_back"}, 32'(maxgap <= 10 * c_div + 3), 32'd1);
        end
    endtask

    vec_t dir[4];

    initial begin
        vec_t v;
        int rb, tb0, eb, k;
        dir[0] = mk(8'h57, 32'h3000_0004, 32'h0000_0041, 32'h0, 3, 0, 8'h06, 0, 1, 1, 3, 0);
        dir[1] = mk(8'h52, 32'h3000_0000, 32'h0, 32'hDEAD_BEEF, 1, 0, 8'h06, 4, 1, 0, 1, 0);
        dir[2] = mk(8'h13, 32'h0, 32'h0, 32'h0, 1, 0, 8'h15, 0, 0, 0, 0, 1);
        dir[3] = mk(8'h52, 32'h1234_5678, 32'h0, 32'h0055_AAFF, 2, 5, 8'h06, 4, 1, 0, 2, 0);

        wb_rst_i = 1'b1;
        rx = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst:tx", 32'(tx), 32'd1);
        check("rst:cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst:stb", 32'(wbm_stb_o), 32'd0);
        check("rst:we", 32'(wbm_we_o), 32'd0);
        check("rst:sel", 32'(wbm_sel_o), 32'd0);
        check("rst:adr", wbm_adr_o, 32'd0);
        check("rst:dat", wbm_dat_o, 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:err", 32'(err_o), 32'd0);
        repeat (20) @(negedge wb_clk_i);

        for (int i = 0; i < 4; i++) apply_vec(dir[i], $sformatf("dir%0d", i));

        // framing error in the third address byte
        rb = rxq.size(); tb0 = txnq.size(); eb = err_total;
        send_byte(8'h57, 1'b1, 0);
        send_byte(8'h30, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        repeat (300) @(negedge wb_clk_i);
        check("ferr:err_pulses", 32'(err_total - eb), 32'd1);
        check("ferr:busy", 32'(busy), 32'd0);
        check("ferr:bus_cycles", 32'(txnq.size() - tb0), 32'd0);
        check("ferr:resp_count", 32'(rxq.size() - rb), 32'd0);
        apply_vec(mk(8'h57, 32'h3000_0004, 32'hCAFE_0042, 32'h0, 2, 0, 8'h06, 0, 1, 1, 2, 0), "ferr_next");

        // read whose slave is slow or silent
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        apply_vec(mk(8'h52, 32'h3000_0000, 32'h0, 32'h1111_2222, 0, 0, 8'h15, 0, 1, 0, 10, 1), "timeout");
`else
        apply_vec(mk(8'h52, 32'h3000_0000, 32'h0, 32'h1111_2222, 500, 0, 8'h06, 4, 1, 0, 500, 0), "slow_ack");
`endif

        // reset while the bus cycle is open
        rb = rxq.size();
        ack_lat = 0;
        send_byte(8'h52, 1'b1, 0);
        for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b1, 0);
        k = 0;
        while (wbm_cyc_o !== 1'b1 && k < 200) begin
            @(negedge wb_clk_i);
            k++;
        end
        check("rstbus:cyc_seen", 32'(wbm_cyc_o), 32'd1);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check("rstbus:cyc", 32'(wbm_cyc_o), 32'd0);
        check("rstbus:stb", 32'(wbm_stb_o), 32'd0);
        check("rstbus:tx", 32'(tx), 32'd1);
        check("rstbus:busy", 32'(busy), 32'd0);
        repeat (400) @(negedge wb_clk_i);
        check("rstbus:resp_count", 32'(rxq.size() - rb), 32'd0);

        // randomized frames against the reference model
        for (int i = 0; i < 6; i++) begin
            v.adr  = $urandom;
            v.wdat = $urandom;
            v.rdat = $urandom;
            v.lat  = $urandom_range(1, 8);
            v.gap  = $urandom_range(0, 40);
            case ($urandom_range(0, 2))
                0:       v.cmd = 8'h57;
                1:       v.cmd = 8'h52;
                default: begin
                    v.cmd = 8'($urandom_range(0, 255));
                    if (v.cmd == 8'h57 || v.cmd == 8'h52) v.cmd = 8'hFF;
                end
            endcase
            apply_vec(model(v), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
